// File: rtl/os_inst_sequencer.sv
// ---------------------------------------------------------------------------
// os_inst_sequencer
//
// Generates the 40-bit instruction stream for the output-stationary core.
// For each of cfg_tiles tiles it:
//   1. FEED  : streams activation/weight xmem address pairs, stalling while
//              L0 or IFIFO cannot accept,
//   2. DRAIN : issues drain_len shift cycles (mode=1, load=1),
//   3. FLUSH : idles ctrl_dly+2 cycles so delayed controls and the l0/ififo
//              read strobes land,
//   4. READ  : reads `row` results from the OFIFO, writing each one into
//              pmem on the following cycle.
//
// Parameters
//   row        OFIFO results read per tile
//   len_nij    maximum vectors per tile (sizes cfg_len)
//   drain_len  shift cycles per tile
//   ctrl_dly   extra register stages on mode/execute/load (must be >= 1)
//
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   start           single-cycle start pulse, sampled only in IDLE
//   cfg_len         vectors per tile (0..len_nij)
//   cfg_tiles       number of tiles
//   cfg_act_base    xmem bank-0 activation base address
//   cfg_wgt_base    xmem bank-1 weight base address
//   cfg_psum_base   pmem base address
//   l0_ready        L0 can accept a vector
//   ififo_ready     IFIFO can accept a vector
//   ofifo_valid     OFIFO holds a full row
//   inst            registered core instruction word
//   busy            high from the cycle after an accepted start until done
//   done            one-cycle pulse after the last pmem write
// ---------------------------------------------------------------------------
module os_inst_sequencer #(
  parameter int row       = 8,
  parameter int len_nij   = 27,
  parameter int drain_len = 16,
  parameter int ctrl_dly  = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [$clog2(len_nij+1)-1:0]     cfg_len,
  input  logic [3:0]                       cfg_tiles,
  input  logic [7:0]                       cfg_act_base,
  input  logic [7:0]                       cfg_wgt_base,
  input  logic [8:0]                       cfg_psum_base,
  input  logic                             l0_ready,
  input  logic                             ififo_ready,
  input  logic                             ofifo_valid,
  output logic [39:0]                      inst,
  output logic                             busy,
  output logic                             done
);

  localparam int LW = $clog2(len_nij + 1);
  localparam int DW = $clog2(drain_len + 1);
  localparam int FW = $clog2(ctrl_dly + 3);
  localparam int JW = $clog2(row + 1);

  // All CEN/WEN high, everything else low.
  localparam logic [39:0] IDLE_WORD = 40'h30_0403_0000;

  // mode/execute/load encodings, bit order {mode, execute, load}
  localparam logic [2:0] CTRL_NONE  = 3'b000;
  localparam logic [2:0] CTRL_FEED  = 3'b110;
  localparam logic [2:0] CTRL_DRAIN = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_FLUSH,
    S_READ,
    S_DONE
  } state_t;

  state_t          state_q,     state_d;
  logic [LW-1:0]   k_q,         k_d;
  logic [3:0]      tile_q,      tile_d;
  logic [LW-1:0]   len_q,       len_d;
  logic [3:0]      tiles_q,     tiles_d;
  logic [7:0]      act_tile_q,  act_tile_d;   // act_base + tile*cfg_len
  logic [7:0]      wgt_base_q,  wgt_base_d;
  logic [8:0]      psum_tile_q, psum_tile_d;  // psum_base + tile*row
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [JW-1:0]   j_q,         j_d;
  logic            wr_pend_q,   wr_pend_d;    // an ofifo_rd awaits its pmem write
  logic            busy_q,      busy_d;
  logic            done_q,      done_d;
  logic [39:0]     inst_q,      inst_d;

  // Control delay line: stage 0 is loaded in the same cycle the address
  // fields are registered into inst_q, so after ctrl_dly stages plus the
  // inst register the controls trail their addresses by exactly ctrl_dly.
  logic [2:0]      ctrl_pipe_q [ctrl_dly];
  logic [2:0]      ctrl_pipe_d [ctrl_dly];
  logic [2:0]      ctrl_raw;

  // Per-cycle instruction fields before packing
  logic            cen_p, wen_p, cen1, cen0, wen0, ofifo_rd;
  logic [8:0]      a_p;
  logic [7:0]      a1, a0;

  genvar gi;
  generate
    for (gi = 0; gi < ctrl_dly; gi++) begin : g_ctrl
      if (gi == 0) begin : g_head
        assign ctrl_pipe_d[gi] = ctrl_raw;
      end else begin : g_tail
        assign ctrl_pipe_d[gi] = ctrl_pipe_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    tile_d      = tile_q;
    len_d       = len_q;
    tiles_d     = tiles_q;
    act_tile_d  = act_tile_q;
    wgt_base_d  = wgt_base_q;
    psum_tile_d = psum_tile_q;
    drain_cnt_d = drain_cnt_q;
    flush_cnt_d = flush_cnt_q;
    j_d         = j_q;
    wr_pend_d   = wr_pend_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    cen_p    = 1'b1;
    wen_p    = 1'b1;
    a_p      = '0;
    cen1     = 1'b1;
    a1       = '0;
    cen0     = 1'b1;
    wen0     = 1'b1;
    a0       = '0;
    ofifo_rd = 1'b0;
    ctrl_raw = CTRL_NONE;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d       = cfg_len;
          tiles_d     = cfg_tiles;
          act_tile_d  = cfg_act_base;
          wgt_base_d  = cfg_wgt_base;
          psum_tile_d = cfg_psum_base;
          k_d         = '0;
          tile_d      = '0;
          busy_d      = 1'b1;
          if ((cfg_len == '0) || (cfg_tiles == 4'd0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FEED;
          end
        end
      end

      S_FEED: begin
        // Ready is sampled in the very cycle the word is registered, so a
        // not-ready cycle simply leaves xmem disabled and k unchanged.
        if (l0_ready && ififo_ready) begin
          cen0     = 1'b0;
          a0       = act_tile_q + 8'(k_q);
          cen1     = 1'b0;
          a1       = wgt_base_q + 8'(k_q);
          ctrl_raw = CTRL_FEED;
          k_d      = k_q + LW'(1);
          if (k_q == len_q - LW'(1)) begin
            drain_cnt_d = '0;
            state_d     = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        ctrl_raw    = CTRL_DRAIN;
        drain_cnt_d = drain_cnt_q + DW'(1);
        if (drain_cnt_q == DW'(drain_len - 1)) begin
          flush_cnt_d = '0;
          state_d     = S_FLUSH;
        end
      end

      S_FLUSH: begin
        flush_cnt_d = flush_cnt_q + FW'(1);
        if (flush_cnt_q == FW'(ctrl_dly + 1)) begin
          j_d       = '0;
          wr_pend_d = 1'b0;
          state_d   = S_READ;
        end
      end

      S_READ: begin
        // Reads and writes alternate: each ofifo_rd is followed by the pmem
        // write of that result before the next read is considered.
        if (wr_pend_q) begin
          cen_p     = 1'b0;
          wen_p     = 1'b0;
          a_p       = psum_tile_q + 9'(j_q) - 9'd1;
          wr_pend_d = 1'b0;
          if (j_q == JW'(row)) begin
            tile_d      = tile_q + 4'd1;
            k_d         = '0;
            act_tile_d  = act_tile_q + 8'(len_q);
            psum_tile_d = psum_tile_q + 9'(row);
            if (tile_q + 4'd1 == tiles_q) begin
              state_d = S_DONE;
            end else begin
              state_d = S_FEED;
            end
          end
        end else if (ofifo_valid && (j_q < JW'(row))) begin
          ofifo_rd  = 1'b1;
          j_d       = j_q + JW'(1);
          wr_pend_d = 1'b1;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Buffer strobes are derived from the previously registered word:
    // l0_wr/ififo_wr follow an xmem read by one cycle, and the matching
    // reads follow the writes by one more.
    inst_d = {2'b00,
              cen_p, wen_p, a_p,
              cen1, a1,
              cen0, wen0, a0,
              ofifo_rd,
              ~inst_q[26],
              inst_q[6],
              inst_q[3],
              ~inst_q[17] & inst_q[16],
              ctrl_pipe_q[ctrl_dly-1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      tile_q      <= '0;
      len_q       <= '0;
      tiles_q     <= '0;
      act_tile_q  <= '0;
      wgt_base_q  <= '0;
      psum_tile_q <= '0;
      drain_cnt_q <= '0;
      flush_cnt_q <= '0;
      j_q         <= '0;
      wr_pend_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      inst_q      <= IDLE_WORD;
      for (int i = 0; i < ctrl_dly; i++) begin
        ctrl_pipe_q[i] <= CTRL_NONE;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      tile_q      <= tile_d;
      len_q       <= len_d;
      tiles_q     <= tiles_d;
      act_tile_q  <= act_tile_d;
      wgt_base_q  <= wgt_base_d;
      psum_tile_q <= psum_tile_d;
      drain_cnt_q <= drain_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      j_q         <= j_d;
      wr_pend_q   <= wr_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      inst_q      <= inst_d;
      for (int i = 0; i < ctrl_dly; i++) begin
        ctrl_pipe_q[i] <= ctrl_pipe_d[i];
      end
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_os_inst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_os_inst_sequencer
//
// Table-driven bench for os_inst_sequencer with default parameters
// (row=8, len_nij=27, drain_len=16, ctrl_dly=3). Each table record gives
// the configuration, stall/valid stimulus and hand-computed totals; a small
// address model checks every xmem/pmem address as it appears. Hand-written
// sequences cover reset state and an asynchronous reset in the middle of FEED.
// ---------------------------------------------------------------------------
module tb_os_inst_sequencer;

  localparam logic [39:0] IDLE_WORD = 40'h30_0403_0000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  cfg_len;
  logic [3:0]  cfg_tiles;
  logic [7:0]  cfg_act_base;
  logic [7:0]  cfg_wgt_base;
  logic [8:0]  cfg_psum_base;
  logic        l0_ready;
  logic        ififo_ready;
  logic        ofifo_valid;
  logic [39:0] inst;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  os_inst_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cfg_len       (cfg_len),
    .cfg_tiles     (cfg_tiles),
    .cfg_act_base  (cfg_act_base),
    .cfg_wgt_base  (cfg_wgt_base),
    .cfg_psum_base (cfg_psum_base),
    .l0_ready      (l0_ready),
    .ififo_ready   (ififo_ready),
    .ofifo_valid   (ofifo_valid),
    .inst          (inst),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stall: 0 none, 1 toggle l0_ready, 2 toggle ififo_ready
  // valid_from: first edge (counted from the start edge) with ofifo_valid=1
  // restart_e: edge at which a second start is driven (-1 none)
  typedef struct {
    logic [4:0] len;
    logic [3:0] tiles;
    logic [7:0] act;
    logic [7:0] wgt;
    logic [8:0] psum;
    int         stall;
    int         valid_from;
    int         restart_e;
    int         exp_feeds;
    int         exp_writes;
    int         exp_loads;
    int         exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          k_m, t_m, wr_idx, feeds, loads, rds, dones, lat, last_rd, fe, tmp;
    int          strobe_err, busy_err, ctrl_err, post_err;
    int          fq[$];
    logic [39:0] prev, cur;
    logic        rdy_cur, vld_cur, exp_busy;
    logic [7:0]  ea, eb;
    logic [8:0]  ep;

    k_m = 0; t_m = 0; wr_idx = 0; feeds = 0; loads = 0; rds = 0; dones = 0;
    lat = -1; last_rd = -10;
    strobe_err = 0; busy_err = 0; ctrl_err = 0; post_err = 0;

    @(negedge clk);
    cfg_len       = v.len;
    cfg_tiles     = v.tiles;
    cfg_act_base  = v.act;
    cfg_wgt_base  = v.wgt;
    cfg_psum_base = v.psum;
    l0_ready      = 1'b1;
    ififo_ready   = 1'b1;
    ofifo_valid   = (0 >= v.valid_from);
    start         = 1'b1;
    rdy_cur       = 1'b1;
    vld_cur       = ofifo_valid;
    prev          = inst;

    for (int e = 0; e < 400; e++) begin
      @(negedge clk);
      cur = inst;

      if (cur[39:38] !== 2'b00) ctrl_err++;
      if (cur[3] !== (~prev[17] & prev[16])) strobe_err++;
      if (cur[6] !== ~prev[26]) strobe_err++;
      if (cur[4] !== prev[3]) strobe_err++;
      if (cur[5] !== prev[6]) strobe_err++;

      exp_busy = !((done === 1'b1) || (lat >= 0));
      if (busy !== exp_busy) busy_err++;

      if (cur[17] === 1'b0) begin
        tmp = int'(v.act) + t_m * int'(v.len) + k_m;
        ea  = tmp[7:0];
        tmp = int'(v.wgt) + k_m;
        eb  = tmp[7:0];
        chk("a0_addr", cur[15:8], ea);
        chk("a1_addr", cur[25:18], eb);
        chk("feed_ready", rdy_cur, 1);
        if (cur[26] !== 1'b0 || cur[16] !== 1'b1) ctrl_err++;
        fq.push_back(e);
        feeds++;
        k_m++;
        if (k_m == int'(v.len)) begin
          k_m = 0;
          t_m++;
        end
      end else if (cur[26] !== 1'b1) begin
        ctrl_err++;
      end

      if (cur[1] === 1'b1) begin
        if (fq.size() == 0) begin
          ctrl_err++;
        end else begin
          fe = fq.pop_front();
          chk("exec_lag", e - fe, 3);
        end
        if (cur[2] !== 1'b1 || cur[0] !== 1'b0) ctrl_err++;
      end

      if (cur[0] === 1'b1) begin
        loads++;
        if (cur[2] !== 1'b1) ctrl_err++;
      end

      if (cur[7] === 1'b1) begin
        rds++;
        chk("rd_valid", vld_cur, 1);
        last_rd = e;
      end

      if (cur[37] === 1'b0) begin
        tmp = int'(v.psum) + wr_idx;
        ep  = tmp[8:0];
        chk("pmem_addr", cur[35:27], ep);
        if (cur[36] !== 1'b0 || last_rd != e - 1) ctrl_err++;
        wr_idx++;
      end else if (cur[36] !== 1'b1) begin
        ctrl_err++;
      end

      if (lat >= 0 && cur !== IDLE_WORD) post_err++;

      if (done === 1'b1) begin
        dones++;
        if (lat < 0) lat = e;
      end

      prev = cur;

      // drive inputs for edge e+1
      start = (e + 1 == v.restart_e);
      if (e == 0 || e + 1 == v.restart_e) begin
        cfg_len       = 5'($urandom_range(1, 27));
        cfg_tiles     = 4'($urandom_range(1, 15));
        cfg_act_base  = 8'($urandom);
        cfg_wgt_base  = 8'($urandom);
        cfg_psum_base = 9'($urandom);
      end
      l0_ready    = (v.stall == 1) ? ((e + 1) % 2 == 0) : 1'b1;
      ififo_ready = (v.stall == 2) ? ((e + 1) % 2 == 0) : 1'b1;
      ofifo_valid = (e + 1 >= v.valid_from);
      rdy_cur     = l0_ready & ififo_ready;
      vld_cur     = ofifo_valid;

      if (lat >= 0 && e >= lat + 4) break;
    end

    start = 1'b0;
    chk("feeds", feeds, v.exp_feeds);
    chk("pmem_writes", wr_idx, v.exp_writes);
    chk("ofifo_reads", rds, v.exp_writes);
    chk("load_cycles", loads, v.exp_loads);
    chk("done_pulses", dones, 1);
    chk("latency", lat, v.exp_lat);
    chk("exec_pending", fq.size(), 0);
    chk("strobes", strobe_err, 0);
    chk("busy", busy_err, 0);
    chk("ctrl_fields", ctrl_err, 0);
    chk("post_done_idle", post_err, 0);
    $display("vec %0d: len=%0d tiles=%0d feeds=%0d writes=%0d loads=%0d latency=%0d",
             idx, v.len, v.tiles, feeds, wr_idx, loads, lat);
  endtask

  initial begin
    int quiet_err;

    //          len    tiles  act     wgt     psum     stall vfrom restart feeds writes loads lat
    vecs[0] = '{5'd27, 4'd1, 8'h00, 8'h80, 9'h000, 0,    0,    -1,     27,   8,     16,   65};
    vecs[1] = '{5'd27, 4'd1, 8'h00, 8'h80, 9'h000, 1,    0,    -1,     27,   8,     16,   92};
    vecs[2] = '{5'd27, 4'd1, 8'h00, 8'h80, 9'h000, 0,    69,   -1,     27,   8,     16,   85};
    vecs[3] = '{5'd4,  4'd3, 8'h00, 8'h80, 9'h100, 0,    0,    10,     12,   24,    48,   124};
    vecs[4] = '{5'd4,  4'd1, 8'hFE, 8'h80, 9'h000, 0,    0,    -1,     4,    8,     16,   42};
    vecs[5] = '{5'd4,  4'd1, 8'h10, 8'hF0, 9'h1FC, 2,    0,    -1,     4,    8,     16,   46};
    vecs[6] = '{5'd0,  4'd2, 8'h00, 8'h80, 9'h000, 0,    0,    -1,     0,    0,     0,    1};
    vecs[7] = '{5'd5,  4'd0, 8'h00, 8'h80, 9'h000, 0,    0,    -1,     0,    0,     0,    1};

    reset         = 1'b1;
    start         = 1'b0;
    cfg_len       = '0;
    cfg_tiles     = '0;
    cfg_act_base  = '0;
    cfg_wgt_base  = '0;
    cfg_psum_base = '0;
    l0_ready      = 1'b1;
    ififo_ready   = 1'b1;
    ofifo_valid   = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_inst", inst, IDLE_WORD);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i]);
    end

    // Asynchronous reset in the middle of FEED
    @(negedge clk);
    cfg_len       = 5'd27;
    cfg_tiles     = 4'd1;
    cfg_act_base  = 8'h00;
    cfg_wgt_base  = 8'h80;
    cfg_psum_base = 9'h000;
    l0_ready      = 1'b1;
    ififo_ready   = 1'b1;
    ofifo_valid   = 1'b1;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("midfeed_active", inst[17], 0);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_inst", inst, IDLE_WORD);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    quiet_err = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (inst !== IDLE_WORD || busy !== 1'b0 || done !== 1'b0) quiet_err++;
    end
    chk("post_reset_quiet", quiet_err, 0);
    $display("reset sequence: mid-FEED reset applied, %0d quiet cycles observed", 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
